// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
// qpsk_pkg : shared widths, state encoding and dibit-to-level mapping for QPSK
// Revision : 1.0
// ============================================================================
package qpsk_pkg;

  localparam int SYM_W       = 11;
  localparam int AMP_DEFAULT = 724;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // One axis of the constellation: a set bit selects the negative level.
  function automatic logic signed [SYM_W-1:0] qpsk_level(input logic neg, input int amp);
    logic signed [SYM_W-1:0] mag;
    mag = amp[SYM_W-1:0];
    return neg ? -mag : mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_if.sv
`default_nettype none
// ============================================================================
// qpsk_if : byte handshake in, symbol strobe and I/Q out of the QPSK modulator
// Revision : 1.0
// ============================================================================
interface qpsk_if
  import qpsk_pkg::*;
();

  logic                    valid_i;
  logic [7:0]              data_i;
  logic                    ready_o;
  logic                    valid_a;
  logic signed [SYM_W-1:0] ar;
  logic signed [SYM_W-1:0] ai;

  modport master (
    output valid_i, data_i,
    input  ready_o, valid_a, ar, ai
  );

  modport slave (
    input  valid_i, data_i,
    output ready_o, valid_a, ar, ai
  );

endinterface
`default_nettype wire

// File: rtl/qpsk_map.sv
`default_nettype none
// ============================================================================
// qpsk_map : combinational dibit to (ar, ai) constellation point
// Revision : 1.0
// ============================================================================
module qpsk_map
  import qpsk_pkg::*;
#(
  parameter int AMP = AMP_DEFAULT
) (
  input  logic [1:0]              dibit,
  output logic signed [SYM_W-1:0] ar,
  output logic signed [SYM_W-1:0] ai
);

  assign ar = qpsk_level(dibit[1], AMP);
  assign ai = qpsk_level(dibit[0], AMP);

endmodule
`default_nettype wire

// File: rtl/qpsk_mod.sv
`default_nettype none
// ============================================================================
// qpsk_mod : byte-to-QPSK modulator, MSB-first dibits, one point per period
// Revision : 1.0
// ============================================================================
module qpsk_mod
  import qpsk_pkg::*;
#(
  parameter int AMP        = AMP_DEFAULT,
  parameter int SYM_PERIOD = 1
) (
  input  logic  CLK,
  input  logic  RST,
  qpsk_if.slave bus
);

  localparam int              PC_W      = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam logic [PC_W-1:0] C_PC_LAST = PC_W'(SYM_PERIOD - 1);
  localparam logic [PC_W-1:0] C_PC_ONE  = PC_W'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_remaining;
  logic [1:0]              w_remaining_nxt;
  logic [PC_W-1:0]         r_pc;
  logic [PC_W-1:0]         w_pc_nxt;
  logic [5:0]              r_shift;
  logic [5:0]              w_shift_nxt;
  logic                    r_valid_a;
  logic                    w_valid_a_nxt;
  logic                    w_load;
  logic signed [SYM_W-1:0] r_ar;
  logic signed [SYM_W-1:0] r_ai;
  logic signed [SYM_W-1:0] w_map_ar;
  logic signed [SYM_W-1:0] w_map_ai;
  logic                    w_pc_last;
  logic                    w_ready;
  logic                    w_accept;
  logic [1:0]              w_dibit;

  assign w_pc_last = (r_pc == C_PC_LAST);
  assign w_ready   = (r_state == ST_IDLE) || ((r_remaining == 2'd0) && w_pc_last);
  assign w_accept  = bus.valid_i && w_ready;

  // The leading dibit bypasses the shift register so it goes out one cycle after accept.
  assign w_dibit = w_accept ? bus.data_i[7:6] : r_shift[5:4];

  qpsk_map #(
    .AMP (AMP)
  ) u_map (
    .dibit (w_dibit),
    .ar    (w_map_ar),
    .ai    (w_map_ai)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pc_nxt        = r_pc;
    w_shift_nxt     = r_shift;
    w_valid_a_nxt   = 1'b0;
    w_load          = 1'b0;

    if (w_accept) begin
      w_state_nxt     = ST_BUSY;
      w_shift_nxt     = bus.data_i[5:0];
      w_remaining_nxt = 2'd3;
      w_pc_nxt        = '0;
      w_valid_a_nxt   = 1'b1;
      w_load          = 1'b1;
    end else if (r_state == ST_BUSY) begin
      if (!w_pc_last) begin
        w_pc_nxt = r_pc + C_PC_ONE;
      end else if (r_remaining != 2'd0) begin
        w_shift_nxt     = {r_shift[3:0], 2'b00};
        w_remaining_nxt = r_remaining - 2'd1;
        w_pc_nxt        = '0;
        w_valid_a_nxt   = 1'b1;
        w_load          = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_remaining <= 2'd0;
      r_pc        <= '0;
      r_shift     <= 6'd0;
      r_valid_a   <= 1'b0;
      r_ar        <= '0;
      r_ai        <= '0;
    end else begin
      r_remaining <= w_remaining_nxt;
      r_pc        <= w_pc_nxt;
      r_shift     <= w_shift_nxt;
      r_valid_a   <= w_valid_a_nxt;
      if (w_load) begin
        r_ar <= w_map_ar;
        r_ai <= w_map_ai;
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_a = r_valid_a;
  assign bus.ar      = r_ar;
  assign bus.ai      = r_ai;

endmodule
`default_nettype wire
